// File: rtl/pcie_stream_pkg.sv
// Shared constants for the PCIe C2H streaming path: data width, line size
// and channel IDs used by the arbiter and the video packers.
package pcie_stream_pkg;
  localparam int   DATA_W       = 64;
  localparam int   VIDEO_LENGTH = 1920;
  // 4 pixels are packed per 64-bit word
  localparam int   LINE_WORDS   = VIDEO_LENGTH / 4;
  localparam logic CH0          = 1'b0;
  localparam logic CH1          = 1'b1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;
endpackage

// File: rtl/c2h_stream_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the channel not served last wins,
// otherwise the single requester is chosen (sel is don't-care with no request).
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel
);
  assign sel = (&req) ? ~last : req[1];
endmodule

// File: rtl/c2h_stream_arbiter.sv
// Line-granular two-channel AXI-Stream arbiter onto the XDMA C2H stream.
// Grants are held for a whole line, with length enforcement and sticky errors.
module c2h_stream_arbiter #(
  parameter int DATA_W     = pcie_stream_pkg::DATA_W,
  parameter int LINE_WORDS = pcie_stream_pkg::LINE_WORDS,
  parameter int CNT_W      = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        ch_en,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  input  logic              s0_tlast,
  output logic              s0_tready,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  input  logic              s1_tlast,
  output logic              s1_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              m_tuser,
  output logic              line_done,
  output logic              line_ch,
  output logic [1:0]        err_len,
  input  logic              err_clr
);
  import pcie_stream_pkg::*;

  arb_state_t        state;
  logic              grant, last_grant, sel;
  logic [CNT_W-1:0]  wcnt;
  logic [1:0]        req;
  logic              busy, g_tvalid, g_tlast, at_end, eff_last, accept, len_bad;
  logic [DATA_W-1:0] g_tdata;

  assign req = ch_en & {s1_tvalid, s0_tvalid};

  rr_pick2 u_pick (.req(req), .last(last_grant), .sel(sel));

  assign busy     = (state == BUSY);
  assign g_tdata  = (grant == CH1) ? s1_tdata  : s0_tdata;
  assign g_tvalid = (grant == CH1) ? s1_tvalid : s0_tvalid;
  assign g_tlast  = (grant == CH1) ? s1_tlast  : s0_tlast;

  // Terminate on the source's tlast or on the nominal line length, whichever first
  assign at_end   = (wcnt == CNT_W'(LINE_WORDS - 1));
  assign eff_last = g_tlast | at_end;

  assign m_tdata   = busy ? g_tdata : '0;
  assign m_tvalid  = busy & g_tvalid;
  assign m_tlast   = busy & eff_last;
  assign m_tuser   = busy & grant;
  assign s0_tready = busy & (grant == CH0) & m_tready;
  assign s1_tready = busy & (grant == CH1) & m_tready;

  assign accept  = m_tvalid & m_tready;
  assign len_bad = accept & eff_last & (g_tlast != at_end);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      grant      <= CH0;
      last_grant <= CH1;
      wcnt       <= '0;
      line_done  <= 1'b0;
      line_ch    <= CH0;
      err_len    <= 2'b00;
    end else begin
      line_done <= 1'b0;
      // A new error in the same cycle as a clear must survive
      err_len   <= (err_clr ? 2'b00 : err_len) | (len_bad ? (2'b01 << grant) : 2'b00);
      case (state)
        IDLE: begin
          if (|req) begin
            state <= BUSY;
            grant <= sel;
            wcnt  <= '0;
          end
        end
        BUSY: begin
          if (accept) begin
            if (eff_last) begin
              state      <= IDLE;
              last_grant <= grant;
              line_done  <= 1'b1;
              line_ch    <= grant;
              wcnt       <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_c2h_stream_arbiter.sv
// Directed bench for c2h_stream_arbiter with 8-word lines: a table of line
// scenarios plus hand-written reset sequences.
module tb_c2h_stream_arbiter;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    ch_en;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic          m_tvalid, m_tlast, m_tready, m_tuser;
  logic          line_done, line_ch, err_clr;
  logic [1:0]    err_len;

  c2h_stream_arbiter #(.DATA_W(DW), .LINE_WORDS(LW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .ch_en(ch_en),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .m_tuser(m_tuser), .line_done(line_done), .line_ch(line_ch),
    .err_len(err_len), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Simple sources: beat counters advance on handshake, tlast at a configured beat
  logic [1:0]  src_on;
  logic        src_clr;
  logic [15:0] sb0, sb1;
  int          tl0, tl1, cur_vec;

  always @(posedge clk) begin
    if (src_clr) begin
      sb0 <= '0;
      sb1 <= '0;
    end else begin
      if (s0_tvalid && s0_tready) sb0 <= sb0 + 16'd1;
      if (s1_tvalid && s1_tready) sb1 <= sb1 + 16'd1;
    end
  end

  assign s0_tvalid = src_on[0];
  assign s1_tvalid = src_on[1];
  assign s0_tlast  = (tl0 != 0) && (int'(sb0) + 1 == tl0);
  assign s1_tlast  = (tl1 != 0) && (int'(sb1) + 1 == tl1);
  assign s0_tdata  = {8'hC0, 23'd0, 1'b0, cur_vec[15:0], sb0};
  assign s1_tdata  = {8'hC0, 23'd0, 1'b1, cur_vec[15:0], sb1};

  typedef struct {
    logic [1:0] en;
    logic [1:0] on;
    int         tl0;
    int         tl1;
    bit         bp;
    int         drop_at;
    bit         clr_hold;
    bit         clr_after;
    logic       exp_ch;
    int         exp_beats;
    logic [1:0] exp_err;
  } vec_t;

  vec_t vt [14];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(logic [1:0] en, logic [1:0] on, int t0, int t1, bit bp,
                              int drop, bit ch_hold, bit ca, logic ch, int nb, logic [1:0] er);
    vec_t v;
    v.en = en; v.on = on; v.tl0 = t0; v.tl1 = t1; v.bp = bp; v.drop_at = drop;
    v.clr_hold = ch_hold; v.clr_after = ca; v.exp_ch = ch; v.exp_beats = nb; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int beats, first, data_bad, last_bad, user_bad, stab_bad;
    bit done, stalled;
    logic [DW-1:0] pd, ed;
    logic pl, pu;
    v = vt[i];
    beats = 0; first = -1; data_bad = 0; last_bad = 0; user_bad = 0; stab_bad = 0;
    done = 0; stalled = 0; pd = '0; pl = 0; pu = 0;
    @(negedge clk);
    cur_vec = i; tl0 = v.tl0; tl1 = v.tl1; ch_en = v.en; src_clr = 1'b1;
    src_on = v.on; err_clr = v.clr_hold; m_tready = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      if (line_done) begin
        done = 1;
        break;
      end
      if (stalled && !(m_tvalid && m_tdata == pd && m_tlast == pl && m_tuser == pu)) stab_bad++;
      stalled = m_tvalid && !m_tready;
      pd = m_tdata; pl = m_tlast; pu = m_tuser;
      if (m_tvalid && m_tready) begin
        beats++;
        if (first < 0) first = cyc;
        ed = {8'hC0, 23'd0, v.exp_ch, 16'(i), 16'(beats - 1)};
        if (m_tdata !== ed) data_bad++;
        if (m_tlast !== (beats == v.exp_beats)) last_bad++;
        if (m_tuser !== v.exp_ch) user_bad++;
        if (v.drop_at != 0 && beats == v.drop_at) ch_en[0] = 1'b0;
      end
      @(negedge clk);
      src_clr = 1'b0;
      if (v.bp) m_tready = ~m_tready;
    end
    src_on = 2'b00; err_clr = 1'b0; m_tready = 1'b1;
    if (!done) chk($sformatf("v%0d_timeout", i), 0, 1);
    chk($sformatf("v%0d_line_ch", i), line_ch, v.exp_ch);
    chk($sformatf("v%0d_beats", i), beats, v.exp_beats);
    chk($sformatf("v%0d_data_bad", i), data_bad, 0);
    chk($sformatf("v%0d_tlast_bad", i), last_bad, 0);
    chk($sformatf("v%0d_tuser_bad", i), user_bad, 0);
    chk($sformatf("v%0d_stall_bad", i), stab_bad, 0);
    chk($sformatf("v%0d_err_len", i), err_len, v.exp_err);
    if (!v.bp) chk($sformatf("v%0d_first_beat_cyc", i), first, 1);
    if (v.clr_after) begin
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      #1 chk($sformatf("v%0d_err_cleared", i), err_len, 2'b00);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, {m_tvalid, m_tlast, m_tuser, s0_tready, s1_tready, line_done, line_ch, err_len}, 0);
    chk({name, "_data"}, m_tdata, 0);
  endtask

  initial begin
    //          en     on     tl0 tl1 bp drop hold aft ch  n  err
    vt[0]  = mk(2'b11, 2'b11, 8, 8, 0, 0, 0, 0, 1'b0, 8, 2'b00);
    vt[1]  = mk(2'b11, 2'b11, 8, 8, 0, 0, 0, 0, 1'b1, 8, 2'b00);
    vt[2]  = mk(2'b11, 2'b11, 8, 8, 0, 0, 0, 0, 1'b0, 8, 2'b00);
    vt[3]  = mk(2'b11, 2'b11, 8, 8, 1, 0, 0, 0, 1'b1, 8, 2'b00);
    vt[4]  = mk(2'b11, 2'b10, 8, 5, 0, 0, 0, 1, 1'b1, 5, 2'b10);
    vt[5]  = mk(2'b11, 2'b01, 0, 8, 0, 0, 1, 1, 1'b0, 8, 2'b01);
    vt[6]  = mk(2'b11, 2'b11, 8, 8, 0, 0, 0, 0, 1'b1, 8, 2'b00);
    vt[7]  = mk(2'b01, 2'b11, 8, 8, 1, 0, 0, 0, 1'b0, 8, 2'b00);
    vt[8]  = mk(2'b10, 2'b11, 8, 8, 0, 0, 0, 0, 1'b1, 8, 2'b00);
    vt[9]  = mk(2'b11, 2'b11, 8, 8, 0, 3, 0, 0, 1'b0, 8, 2'b00);
    vt[10] = mk(2'b10, 2'b11, 8, 8, 0, 0, 0, 0, 1'b1, 8, 2'b00);
    vt[11] = mk(2'b10, 2'b11, 8, 8, 0, 0, 0, 0, 1'b1, 8, 2'b00);
    vt[12] = mk(2'b11, 2'b11, 3, 8, 0, 0, 0, 0, 1'b0, 3, 2'b01);
    vt[13] = mk(2'b11, 2'b11, 8, 8, 0, 0, 0, 0, 1'b0, 8, 2'b00);

    // Reset held with both channels streaming
    rstn = 1'b0; ch_en = 2'b11; src_on = 2'b11; src_clr = 1'b1; m_tready = 1'b1;
    err_clr = 1'b0; tl0 = 8; tl1 = 8; cur_vec = 0;
    repeat (3) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    src_on = 2'b00; rstn = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Reset in the middle of a ch1 line: the line is dropped and the tie-break restarts
    @(negedge clk);
    cur_vec = 99; ch_en = 2'b11; src_clr = 1'b1; src_on = 2'b11;
    @(negedge clk);
    src_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("midline_busy_ch1", {m_tvalid, m_tuser}, 2'b11);
    rstn = 1'b0;
    #1 chk_zero("midline_reset");
    repeat (2) @(negedge clk);
    src_on = 2'b00; rstn = 1'b1;
    run_vec(13);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/c2h_stream_arbiter.md
# c2h_stream_arbiter

Two-input, line-granular AXI-Stream arbiter that shares the single XDMA C2H stream between two 64-bit pixel packers (video channel 0 and 1). Grants are held for one complete video line and rotated round-robin between enabled, requesting channels. Each granted line's length is enforced, with a forced `tlast` on overrun and sticky error flags. Sits in the `clk` (XDMA) domain between the packers' AXI-Stream outputs and the XDMA C2H port.

## Interface

**Parameters**
- `DATA_W`, 64: stream data width.
- `LINE_WORDS`, 480: 64-bit words per line (1920 px / 4).
- `CNT_W`, 12: width of the word counter; must satisfy 2^CNT_W > `LINE_WORDS`.

**Ports**
- `clk` in 1: AXI-Stream/XDMA clock; the only clock.
- `rstn` in 1: asynchronous, active-low reset.
- `ch_en` in 2: per-channel enable; bit i gates new grants to channel i.
- `s0_tdata` in `DATA_W`; `s0_tvalid` in 1; `s0_tlast` in 1; `s0_tready` out 1: channel 0 slave stream.
- `s1_tdata` in `DATA_W`; `s1_tvalid` in 1; `s1_tlast` in 1; `s1_tready` out 1: channel 1 slave stream.
- `m_tdata` out `DATA_W`; `m_tvalid` out 1; `m_tlast` out 1; `m_tready` in 1: master stream to XDMA C2H.
- `m_tuser` out 1: channel ID of the current beat.
- `line_done` out 1: one-cycle pulse after a line's final beat is accepted.
- `line_ch` out 1: channel ID of the line that `line_done` reports.
- `err_len` out 2: sticky per-channel line-length error flags.
- `err_clr` in 1: synchronous clear for `err_len`.

## Operation

**State machine**
- States: `IDLE`, `BUSY`.
- Registered state: `grant` (1 bit), `last_grant` (1 bit), `wcnt` (`CNT_W` bits).

**IDLE**
- Request vector: `req[i] = ch_en[i] & si_tvalid`.
- If `req` is nonzero, select a channel and go to `BUSY`. Set `grant` to the selected channel and `wcnt` to 0.
- Round-robin rule: if both channels request, select `~last_grant`. Otherwise select the single requester.
- All `tready` outputs and `m_tvalid` are 0 in this state.

**BUSY**
- Combinational pass-through of the granted channel: `m_tdata`/`m_tvalid` = granted `tdata`/`tvalid`; `granted tready = m_tready`; `m_tuser = grant`.
- The non-granted channel's `tready` is 0.
- A beat is accepted when `m_tvalid & m_tready`; each accepted beat increments `wcnt`.
- Effective last: `eff_last = s_tlast | (wcnt == LINE_WORDS-1)`. `m_tlast = eff_last`, qualified by `BUSY`.
- On an accepted beat with `eff_last`:
  - Go to `IDLE` and set `last_grant <= grant`.
  - Pulse `line_done` on the next cycle, with `line_ch = grant`.
- Length error: if the accepted last beat has `s_tlast != (wcnt == LINE_WORDS-1)`, set `err_len[grant]`. This covers both early `tlast` and a missing `tlast` (forced termination).

**Enable and error-flag rules**
- Deasserting `ch_en[grant]` mid-line does not abort the line. It only blocks future grants.
- `err_clr` clears `err_len` on the clock edge. If a set and a clear coincide, the set wins.

**Width rules**
- `wcnt` never exceeds `LINE_WORDS-1`, so no wrap-around is possible.

## Timing

**Reset values** (asynchronous on `rstn` low):
- State `IDLE`, `grant = 0`, `last_grant = 1` (channel 0 wins the first tie).
- `wcnt = 0`, `line_done = 0`, `line_ch = 0`, `err_len = 0`.
- All stream outputs 0.
- Reset asserted mid-line drops the line. After release, arbitration restarts from `IDLE`.

**Latency and throughput**
- Grant latency: one cycle in `IDLE` after `req` is seen. The first beat can pass on the following cycle.
- Data path: zero-latency combinational mux, no buffering.
- Throughput: one beat per cycle within a line, with one bubble cycle between lines.

**Handshake**
- AXI-Stream rules hold on `m_*`: `m_tdata`, `m_tlast` and `m_tuser` are stable while `m_tvalid & ~m_tready`, provided the source obeys AXI-Stream.
- `si_tready` is never 1 for a channel that is not granted.

## Structure

- Shared package `pcie_stream_pkg`: `DATA_W`, the `LINE_WORDS` derivation (`VIDEO_LENGTH/4`), and channel ID constants `CH0`/`CH1`.
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin picker with inputs `req[1:0]`, `last` and output `sel`.
- The FSM, counter and error logic stay in the top level.

## Test plan

- **Reset behaviour:** `rstn` low with both channels streaming -> all outputs 0. First grant after release is channel 0 when both request.
- **Alternation:** both channels enabled, continuous `tvalid`, `LINE_WORDS = 8` -> lines alternate ch0, ch1, ch0. Each line is 8 beats with `tlast` on beat 8. One `line_done` per line with the matching `line_ch`.
- **Backpressure:** `m_tready` toggling 1-0 per cycle -> no beats lost or duplicated; data held stable while stalled; `wcnt` advances only on accepted beats.
- **Early `tlast`:** ch1 asserts `tlast` on beat 5 of 8 -> line ends after 5 beats, `err_len = 2'b10`. `err_clr` pulse -> `err_len = 0`.
- **Missing `tlast`:** ch0 never asserts `tlast` -> `m_tlast` forced on beat 8, grant released, `err_len[0] = 1`. Ch1 is served next.
- **Enable drop:** `ch_en[0]` dropped at beat 3 of a ch0 line -> the line completes all 8 beats. No further ch0 grants while ch1 is served.
